// File: rtl/lookup_pipe_stage_if.sv
// lookup_pipe_stage_if: FIFO-side pop handshake, output valid/ready bus and
// statistics of the route-lookup register stage.
// master = the environment (FIFO + downstream), slave = the stage itself.
interface lookup_pipe_stage_if #(
    parameter int BBLOCK_W = 32,
    parameter int NHOP_W   = 32
);
    logic                fifo_empty;
    logic                fifo_read;
    logic [BBLOCK_W-1:0] bblock;
    logic [NHOP_W-1:0]   nhop;
    logic                flush;
    logic                out_ready;
    logic                out_valid;
    logic [BBLOCK_W-1:0] previous_bblock;
    logic [NHOP_W-1:0]   previous_nhop;
    logic [31:0]         stat_accept;
    logic [31:0]         stat_stall;

    modport master (
        output fifo_empty, bblock, nhop, flush, out_ready,
        input  fifo_read, out_valid, previous_bblock, previous_nhop,
               stat_accept, stat_stall
    );

    modport slave (
        input  fifo_empty, bblock, nhop, flush, out_ready,
        output fifo_read, out_valid, previous_bblock, previous_nhop,
               stat_accept, stat_stall
    );
endinterface

// File: rtl/lookup_pipe_stage.sv
// lookup_pipe_stage: DEPTH-deep back-pressurable register pipe between a
// show-ahead FIFO and the downstream lookup stage. The whole pipe moves or
// holds as one (bubbles are not collapsed); flush clears every valid bit.
// Optional transfer/stall counters: define LOOKUP_PIPE_STATS_EN.
module lookup_pipe_stage #(
    parameter int BBLOCK_W = 32,
    parameter int NHOP_W   = 32,
    parameter int DEPTH    = 2     // 1..8
) (
    input  logic               core_sp_clk,
    input  logic               reset,        // async, active low
    lookup_pipe_stage_if.slave bus
);
    logic [DEPTH-1:0]               r_v;
    logic [DEPTH-1:0][BBLOCK_W-1:0] r_bb;
    logic [DEPTH-1:0][NHOP_W-1:0]   r_nh;

    logic                           w_advance;
    logic                           w_pop;
    logic [DEPTH-1:0]               w_v_nxt;
    logic [DEPTH-1:0]               w_ld;
    logic [DEPTH-1:0][BBLOCK_W-1:0] w_bb_nxt;
    logic [DEPTH-1:0][NHOP_W-1:0]   w_nh_nxt;

    // Global enable: move unless the tail holds a word nobody takes.
    assign w_advance = !r_v[DEPTH-1] || bus.out_ready;
    // Gating with reset keeps the pop strobe quiet while reset is held.
    assign w_pop     = w_advance && !bus.fifo_empty && !bus.flush && reset;

    // Per-stage next state: stage 0 takes the FIFO head, others the stage before.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_v_nxt[k]  = w_pop;
            assign w_ld[k]     = w_pop;
            assign w_bb_nxt[k] = bus.bblock;
            assign w_nh_nxt[k] = bus.nhop;
        end else begin : g_body
            assign w_v_nxt[k]  = r_v[k-1];
            // Data only follows a valid word, so bubbles leave old data in place.
            assign w_ld[k]     = w_advance && !bus.flush && r_v[k-1];
            assign w_bb_nxt[k] = r_bb[k-1];
            assign w_nh_nxt[k] = r_nh[k-1];
        end
    end

    // Pipeline registers: flush clears valids only, stall holds everything.
    always_ff @(posedge core_sp_clk or negedge reset) begin
        if (!reset) begin
            r_v  <= '0;
            r_bb <= '0;
            r_nh <= '0;
        end else begin
            if (bus.flush)
                r_v <= '0;
            else if (w_advance)
                r_v <= w_v_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_ld[k]) begin
                    r_bb[k] <= w_bb_nxt[k];
                    r_nh[k] <= w_nh_nxt[k];
                end
            end
        end
    end

    assign bus.fifo_read       = w_pop;
    assign bus.out_valid       = r_v[DEPTH-1];
    assign bus.previous_bblock = r_bb[DEPTH-1];
    assign bus.previous_nhop   = r_nh[DEPTH-1];

`ifdef LOOKUP_PIPE_STATS_EN
    logic [31:0] r_acc;
    logic [31:0] r_stl;
    logic        w_xfer;
    logic        w_stall;

    // A transfer still counts in a flush cycle; stalls count while the tail waits.
    assign w_xfer  = r_v[DEPTH-1] && bus.out_ready;
    assign w_stall = r_v[DEPTH-1] && !bus.out_ready;

    // Free-running wrapping counters, cleared only by reset.
    always_ff @(posedge core_sp_clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_stl <= '0;
        end else begin
            if (w_xfer)  r_acc <= r_acc + 32'd1;
            if (w_stall) r_stl <= r_stl + 32'd1;
        end
    end

    assign bus.stat_accept = r_acc;
    assign bus.stat_stall  = r_stl;
`else
    assign bus.stat_accept = '0;
    assign bus.stat_stall  = '0;
`endif
endmodule

// File: tb/tb_lookup_pipe_stage.sv
// tb_lookup_pipe_stage: four stages (DEPTH 1..4) share clock and reset; one is
// active per step. A FIFO model feeds it, popped words go to a scoreboard
// queue and are compared in order when the stage hands them downstream.
module tb_lookup_pipe_stage;
    localparam int N  = 4;
    localparam int BW = 32;
    localparam int NW = 32;

    typedef struct packed {
        logic [31:0]   c;
        logic [BW-1:0] bb;
        logic [NW-1:0] nh;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         t_empty, t_flush, t_ready;
    logic [N-1:0][BW-1:0] t_bb;
    logic [N-1:0][NW-1:0] t_nh;
    logic [N-1:0]         t_read, t_valid;
    logic [N-1:0][BW-1:0] t_pbb;
    logic [N-1:0][NW-1:0] t_pnh;
    logic [N-1:0][31:0]   t_acc, t_stl;

    for (genvar g = 0; g < N; g++) begin : g_dut
        lookup_pipe_stage_if #(.BBLOCK_W(BW), .NHOP_W(NW)) bus ();
        assign bus.fifo_empty = t_empty[g];
        assign bus.bblock     = t_bb[g];
        assign bus.nhop       = t_nh[g];
        assign bus.flush      = t_flush[g];
        assign bus.out_ready  = t_ready[g];
        assign t_read[g]      = bus.fifo_read;
        assign t_valid[g]     = bus.out_valid;
        assign t_pbb[g]       = bus.previous_bblock;
        assign t_pnh[g]       = bus.previous_nhop;
        assign t_acc[g]       = bus.stat_accept;
        assign t_stl[g]       = bus.stat_stall;
        lookup_pipe_stage #(.BBLOCK_W(BW), .NHOP_W(NW), .DEPTH(g + 1)) dut (
            .core_sp_clk (clk),
            .reset       (rst_n),
            .bus         (bus)
        );
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          sel = 1;
    int          cnum = 0;
    int          m_acc = 0;
    int          m_stl = 0;
    logic        ready = 1'b1;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        lat_chk = 1'b0;
    logic        stall_prev = 1'b0;
    logic [BW-1:0] sv_bb;
    logic [NW-1:0] sv_nh;
    word_t       fifo_q[$];
    word_t       exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [BW-1:0] bb, input logic [NW-1:0] nh);
        word_t w;
        w.c = '0; w.bb = bb; w.nh = nh;
        fifo_q.push_back(w);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            t_empty[i] = 1'b1; t_bb[i] = '0; t_nh[i] = '0;
            t_ready[i] = 1'b1; t_flush[i] = 1'b0;
        end
        t_ready[sel] = ready;
        t_flush[sel] = flush;
        if (fifo_q.size() > 0) begin
            t_bb[sel]    = fifo_q[0].bb;
            t_nh[sel]    = fifo_q[0].nh;
            t_empty[sel] = hold;
        end
    endtask

    // One clock: drive, sample at negedge, update models, return at posedge+1.
    task automatic cyc();
        word_t w;
        drive();
        @(negedge clk);
        chk("read_when_empty", t_read[sel] & t_empty[sel], 0);
        if (t_flush[sel]) chk("flush_pop", t_read[sel], 0);
        if (t_valid[sel] && !t_ready[sel]) chk("stall_pop", t_read[sel], 0);
        if (stall_prev) begin
            chk("stall_hold_v", t_valid[sel], 1);
            chk("stall_hold_bb", t_pbb[sel], sv_bb);
            chk("stall_hold_nh", t_pnh[sel], sv_nh);
        end
        if (t_valid[sel] && t_ready[sel]) begin
            m_acc++;
            if (exp_q.size() == 0) chk("spurious_out", t_valid[sel], 0);
            else begin
                w = exp_q.pop_front();
                chk("out_bb", t_pbb[sel], w.bb);
                chk("out_nh", t_pnh[sel], w.nh);
                if (lat_chk) chk("latency", cnum - int'(w.c), sel + 1);
            end
        end
        if (t_valid[sel] && !t_ready[sel]) m_stl++;
        if (t_flush[sel]) exp_q.delete();
        if (t_read[sel] && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            w.c = cnum;
            exp_q.push_back(w);
        end
        stall_prev = t_valid[sel] && !t_ready[sel] && !t_flush[sel];
        sv_bb = t_pbb[sel];
        sv_nh = t_pnh[sel];
        @(posedge clk);
        #1;
        cnum++;
    endtask

    task automatic check_stats();
`ifdef LOOKUP_PIPE_STATS_EN
        chk("stat_accept", t_acc[sel], m_acc);
        chk("stat_stall", t_stl[sel], m_stl);
`else
        chk("stat_accept_off", t_acc[sel], 0);
        chk("stat_stall_off", t_stl[sel], 0);
`endif
    endtask

    // Called at posedge+1: asserts reset between edges, checks, releases.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_valid", t_valid[sel], 0);
        chk("rst_bb", t_pbb[sel], 0);
        chk("rst_nh", t_pnh[sel], 0);
        chk("rst_read", t_read[sel], 0);
        chk("rst_acc", t_acc[sel], 0);
        chk("rst_stl", t_stl[sel], 0);
        exp_q.delete();
        fifo_q.delete();
        m_acc = 0; m_stl = 0; stall_prev = 1'b0;
        hold = 1'b0; flush = 1'b0; ready = 1'b1; lat_chk = 1'b0;
        drive();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drive();
        // Reset values and mid-stream reset, DEPTH=2.
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sel = 1;
        for (int i = 0; i < 4; i++) push_word(32'h50 + i, 32'hB0 + i);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("pre_reset_full", t_valid[sel], 1);
        drive();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_reset_idle", t_valid[sel], 0);
        end

        // Streaming, DEPTH=2.
        lat_chk = 1'b1;
        push_word(32'h11, 32'hA1);
        push_word(32'h22, 32'hA2);
        push_word(32'h33, 32'hA3);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stream_valid_early", t_valid[sel], (i == 1 || i == 2) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) cyc();
        chk("stream_count", m_acc, 3);
        chk("stream_drained", exp_q.size(), 0);
        check_stats();

        // Back-pressure, DEPTH=3.
        @(posedge clk); #1;
        sel = 2;
        apply_reset();
        for (int i = 0; i < 5; i++) push_word(32'h300 + i, $urandom);
        ready = 1'b0;
        for (int i = 0; i < 10 && !t_valid[sel]; i++) cyc();
        chk("bp_fill", t_valid[sel], 1);
        for (int i = 0; i < 4; i++) cyc();
        ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("bp_count", m_acc, 5);
        chk("bp_stalls", m_stl, 4);
        chk("bp_drained", exp_q.size() + fifo_q.size(), 0);
        check_stats();

        // Bubbles, DEPTH=1: FIFO empty every other cycle.
        sel = 0;
        apply_reset();
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) push_word(32'h700 + i, $urandom);
        for (int i = 0; i < 12; i++) begin
            hold = i[0];
            cyc();
            chk("bubble_valid", t_valid[sel], (i % 2 == 0) ? 1 : 0);
        end
        hold = 1'b0;
        cyc();
        chk("bubble_count", m_acc, 6);
        check_stats();

        // Flush, DEPTH=4.
        sel = 3;
        apply_reset();
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) push_word(32'h900 + i, $urandom);
        for (int i = 0; i < 5; i++) cyc();
        chk("flush_pre_full", t_valid[sel], 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_clear", t_valid[sel], 0);
        chk("flush_acc_head", m_acc, 2);
        for (int i = 0; i < 12; i++) cyc();
        chk("flush_count", m_acc, 5);
        chk("flush_drained", exp_q.size() + fifo_q.size(), 0);
        check_stats();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lookup_pipe_stage.md
# lookup_pipe_stage

Parametrised, back-pressurable register stage for the route-lookup pipeline on the core SP clock. It pops {bblock, nhop} words from a show-ahead FIFO, carries them through DEPTH register stages with a valid bit per stage, and presents them on previous_bblock/previous_nhop with a valid/ready handshake. It supports a synchronous flush and optional transfer/stall statistics. It is the general successor to the fixed single-register lookup stage.

## Interface
- BBLOCK_W, 32, width of the bblock field
- NHOP_W, 32, width of the nhop field
- DEPTH, 2, number of register stages; legal range 1..8
- core_sp_clk  in  1  sole clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-low reset
- fifo_empty  in  1  upstream show-ahead FIFO empty flag
- fifo_read  out  1  pop strobe to the upstream FIFO; combinational
- bblock  in  BBLOCK_W  FIFO head data; valid when fifo_empty=0
- nhop  in  NHOP_W  FIFO head next-hop
- flush  in  1  synchronous pipeline clear
- out_ready  in  1  downstream accepts the output word
- out_valid  out  1  output word valid (= valid bit of stage DEPTH-1)
- previous_bblock  out  BBLOCK_W  stage DEPTH-1 bblock
- previous_nhop  out  NHOP_W  stage DEPTH-1 nhop
- stat_accept  out  32  count of completed output transfers
- stat_stall  out  32  count of back-pressured cycles

## Operation
- State per stage k (0..DEPTH-1): v[k], bb[k], nh[k]. Outputs are out_valid=v[DEPTH-1], previous_bblock=bb[DEPTH-1], previous_nhop=nh[DEPTH-1].
- advance = !v[DEPTH-1] | out_ready. This is a global enable: the whole pipeline moves or holds. Bubbles are not collapsed.
- fifo_read = advance & !fifo_empty & !flush.
- On an edge with advance=1 and flush=0:
  - v[0] <= fifo_read; v[k] <= v[k-1].
  - Stage 0 data loads bblock/nhop only when fifo_read=1.
  - Stage k data loads from stage k-1 only when v[k-1]=1. Otherwise data holds.
- On an edge with advance=0 and flush=0: all registers hold.
- flush=1 has priority over advance:
  - All v[k] clear on the next edge.
  - fifo_read=0 in that cycle.
  - Data registers hold.
  - If out_valid & out_ready also hold in that cycle, the transfer still completes and is counted.
- Reset (asynchronous, any time including mid-stream):
  - All v[k], bb[k], nh[k] and both counters go to 0 immediately.
  - fifo_read goes to 0 while reset is asserted.
  - Words in flight are lost.
- The pipeline never pops when full and stalled. With fifo_empty=1 it inserts bubbles (v[0]=0).

## Timing
- Latency: a word popped in cycle c (fifo_read=1) appears with out_valid=1 in cycle c+DEPTH when no stall occurs.
- Throughput: 1 word/cycle while out_ready=1 and fifo_empty=0.
- Stall: while out_valid=1 and out_ready=0, fifo_read=0 and every output is stable.
- Handshake:
  - A transfer occurs in any cycle where out_valid & out_ready.
  - Once asserted, out_valid stays high until a transfer, flush or reset.
- out_ready is allowed to be combinationally dependent on out_valid. There is no combinational path from out_ready to out_valid or to the data outputs. fifo_read depends combinationally on out_ready, fifo_empty and flush.
- Reset values: out_valid=0, previous_bblock=0, previous_nhop=0, fifo_read=0, stat_accept=0, stat_stall=0.

## Configuration
- LOOKUP_PIPE_STATS_EN defined:
  - stat_accept increments on every transfer cycle.
  - stat_stall increments on every cycle with out_valid=1 and out_ready=0.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared only by reset. Flush does not clear them.
- LOOKUP_PIPE_STATS_EN undefined: no counter registers exist, and stat_accept/stat_stall are tied to 0.

## Test plan
- Reset values: DEPTH=2, reset low mid-stream with v[0..1]=1 → all outputs 0 asynchronously; after reset release with fifo_empty=1, out_valid stays 0.
- Streaming: DEPTH=2, FIFO holding 0x11/0xA1, 0x22/0xA2, 0x33/0xA3, out_ready=1 → fifo_read high 3 consecutive cycles; out_valid high cycles c+2..c+4 with data in order; stat_accept=3, stat_stall=0.
- Back-pressure: DEPTH=3, 5 words, out_ready=0 for 4 cycles once out_valid=1 → fifo_read=0 during the stall; outputs frozen on word 0; stat_stall=4; all 5 words delivered in order afterwards with no loss or duplication.
- Bubbles: DEPTH=1, fifo_empty toggles every cycle → out_valid toggles; fifo_read never asserted while fifo_empty=1.
- Flush: DEPTH=4, pipeline full, out_ready=1, flush for 1 cycle → head word transferred (stat_accept+1), all v clear next edge, fifo_read=0 that cycle; the next popped word emerges DEPTH cycles later.
- Config: build without LOOKUP_PIPE_STATS_EN and rerun back-pressure → stat outputs constantly 0; datapath behaviour identical.
